// File: rtl/serial_pkg.sv
// Shared definitions for the host COM serial link.
// Holds the frame FSM encoding and the baud divisor helper.
package serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } tx_state_t;

    function automatic int baud_div(input int oscrate, input int baudrate);
        return oscrate / baudrate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; the head entry is presented on rdata.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter for the host COM link, LSB first.
// Bytes are queued in a FIFO and sent back-to-back with no idle gap.
module uart_tx
    import serial_pkg::*;
#(
    parameter int OSCRATE  = 12_000_000,
    parameter int BAUDRATE = 9600,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int DIV   = baud_div(OSCRATE, BAUDRATE);
    localparam int CNT_W = $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx: OSCRATE / BAUDRATE must be at least 2");
    end

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [7:0]       shift, shift_n;
    logic             tx_q, tx_n;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             baud_end;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (valid),
        .wdata (data),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ready    = !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;
    assign tx       = tx_q;
    assign baud_end = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bit_n    = bit_cnt;
        shift_n  = shift;
        tx_n     = tx_q;
        fifo_pop = 1'b0;
        unique case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_head;
                    tx_n     = 1'b0;
                    cnt_n    = '0;
                    state_n  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    tx_n    = shift[0];
                    bit_n   = '0;
                    cnt_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    cnt_n = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        shift_n = shift >> 1;
                        tx_n    = shift[1];
                        bit_n   = bit_cnt + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    cnt_n = '0;
                    // Chain straight into the next start bit when more is queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_n  = fifo_head;
                        tx_n     = 1'b0;
                        state_n  = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: fast-divisor and default-divisor instances.
// A line receiver model decodes tx and is compared against accepted bytes.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data, data2;
    logic       valid, valid2;
    logic       ready, ready2;
    logic       tx, tx2;
    logic       busy, busy2;

    always #5 clk = ~clk;

    uart_tx #(.OSCRATE(16), .BAUDRATE(1), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy)
    );

    uart_tx dut_def (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data2),
        .valid (valid2),
        .ready (ready2),
        .tx    (tx2),
        .busy  (busy2)
    );

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         starts[$];
    logic       prev_tx = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line receiver: mid-bit sampling of a 16-clock-per-bit 8N1 frame.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && prev_tx === 1'b1) begin
                starts.push_back(cyc);
                repeat (8) @(negedge clk);
                chk("mon_start_bit", {31'd0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    b[i] = tx;
                end
                repeat (16) @(negedge clk);
                chk("mon_stop_bit", {31'd0, tx}, 32'd1);
                rx_q.push_back(b);
                prev_tx = 1'b1;
            end else begin
                prev_tx = tx;
            end
        end
    end

    task automatic flush();
        rx_q.delete();
        exp_q.delete();
        starts.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++)
            chk({tag, "_byte"}, {24'd0, rx_q[j]}, {24'd0, exp_q[j]});
    endtask

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [9:0] got;
        int         bad;
        int         mcount;
        int         pushes;
        logic       exp_rdy;
        logic       v;
        logic [7:0] d;
        logic       do_push;
        logic       do_pop;
        int         t;
        int         ntog;
        int         tog[10];
        logic       last;

        tbl[0] = '{8'hA5, 10'b1_10100101_0};
        tbl[1] = '{8'h00, 10'b1_00000000_0};
        tbl[2] = '{8'hFF, 10'b1_11111111_0};
        tbl[3] = '{8'h55, 10'b1_01010101_0};
        tbl[4] = '{8'h80, 10'b1_10000000_0};
        tbl[5] = '{8'h3C, 10'b1_00111100_0};

        rst_n  = 1'b0;
        data   = '0;
        valid  = 1'b0;
        data2  = '0;
        valid2 = 1'b0;

        #12;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_def", {29'd0, tx2, busy2, ready2}, 32'd5);
        @(negedge clk);
        rst_n = 1'b1;

        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("idle_line", bad, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            chk("tbl_ready", {31'd0, ready}, 32'd1);
            data  = tbl[i].d;
            valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            chk("tbl_not_early", {31'd0, tx}, 32'd1);
            @(negedge clk);
            chk("tbl_latency", {31'd0, tx}, 32'd0);
            for (int k = 0; k < 10; k++) begin
                repeat (k == 0 ? 8 : 16) @(negedge clk);
                got[k] = tx;
            end
            chk("tbl_frame", {22'd0, got}, {22'd0, tbl[i].frame});
            repeat (7) @(negedge clk);
            chk("tbl_busy_stop", {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk("tbl_busy_end", {30'd0, busy, tx}, 32'd1);
        end
        flush();

        // Burst with valid held; bytes after the sixth are 0xFF and must be refused.
        mcount = 0;
        pushes = 0;
        for (int n = 0; n <= 340; n++) begin
            @(negedge clk);
            v       = (n < 320);
            d       = (pushes < 6) ? 8'(pushes + 1) : 8'hFF;
            valid   = v;
            data    = d;
            exp_rdy = (mcount < 4);
            chk("burst_ready", {31'd0, ready}, {31'd0, exp_rdy});
            do_push = v && exp_rdy;
            do_pop  = (mcount > 0) && (n >= 1) && ((n - 1) % 160 == 0);
            if (do_push) begin
                exp_q.push_back(d);
                pushes++;
            end
            mcount = mcount + int'(do_push) - int'(do_pop);
        end
        valid = 1'b0;
        wait_idle("burst", 1500);
        cmp_q("burst");
        chk("burst_frames", starts.size(), 6);
        for (int j = 1; j < starts.size(); j++)
            chk("burst_spacing", starts[j] - starts[j-1], 160);
        repeat (20) @(negedge clk);
        flush();

        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 99) < 3);
            data  = 8'($urandom);
            if (valid && ready) exp_q.push_back(data);
        end
        @(negedge clk);
        valid = 1'b0;
        wait_idle("rnd", 5000);
        repeat (20) @(negedge clk);
        cmp_q("rnd");
        for (int j = 1; j < starts.size(); j++)
            chk("rnd_gap", {31'd0, (starts[j] - starts[j-1]) >= 160}, 32'd1);
        flush();

        @(negedge clk);
        valid = 1'b1;
        data  = 8'h00;
        @(negedge clk);
        data  = 8'h11;
        @(negedge clk);
        data  = 8'h22;
        chk("rstmid_fall", {31'd0, tx}, 32'd0);
        @(negedge clk);
        valid = 1'b0;
        repeat (69) @(negedge clk);
        chk("rstmid_pre", {31'd0, tx}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_tx", {31'd0, tx}, 32'd1);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_hold", {29'd0, tx, busy, ready}, 32'd5);
        rst_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("rstmid_lost", bad, 0);
        flush();

        @(negedge clk);
        data2  = 8'h55;
        valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        t = 0;
        while (tx2 !== 1'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("def_fall", {31'd0, tx2}, 32'd0);
        t    = 0;
        ntog = 0;
        last = 1'b0;
        while (busy2 === 1'b1 && t < 13000) begin
            @(negedge clk);
            t++;
            if (tx2 !== last) begin
                if (ntog < 10) tog[ntog] = t;
                ntog++;
                last = tx2;
            end
        end
        chk("def_toggles", ntog, 9);
        for (int k = 0; k < 9 && k < ntog; k++)
            chk("def_bit_len", tog[k], 1250 * (k + 1));
        chk("def_frame_len", t, 12500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the host COM link: the return path from the APU design to the host, complementing the existing 8N1 receive path on `rx`. It accepts bytes from on-chip logic over a valid/ready handshake and buffers them in a small FIFO. It then serializes them as 8N1 frames on `tx`, LSB first, at `BAUDRATE` derived from `OSCRATE`. It replaces the top-level `rx`→`tx` loop-back when telemetry or register read-back is sent to the host.

## Interface
- `OSCRATE`, default 12_000_000: input clock frequency, Hz.
- `BAUDRATE`, default 9600: serial bit rate, Hz.
- `DEPTH`, default 4: FIFO depth in bytes; must be a power of two, ≥2.

- `clk`  input  1: system clock (`OSCRATE` Hz).
- `rst_n`  input  1: reset, asynchronous assert, active-low.
- `data`  input  8: byte to transmit.
- `valid`  input  1: `data` is offered this cycle.
- `ready`  output  1: FIFO can accept a byte (`!full`).
- `tx`  output  1: serial line, idle high; registered.
- `busy`  output  1: frame in progress or FIFO non-empty.

One clock; reset is asynchronous and active-low. Clock port is `clk`, reset port is `rst_n`.

## Operation
- `DIV = OSCRATE / BAUDRATE`, integer truncation; 1250 at the defaults. Every bit lasts exactly `DIV` clocks. Baud counter width is `$clog2(DIV)`. `DIV < 2` is illegal and must be rejected by an elaboration-time check.
- Handshake: a byte is accepted on a rising edge where `valid && ready`. `data` is sampled only on that edge. `valid` may be held high across multiple transfers, one byte per cycle while `ready` is high.
- FIFO: `DEPTH` entries, count width `$clog2(DEPTH)+1`. `ready = (count != DEPTH)`, combinational from registered count.
  - Full: the push is ignored because `ready` is low.
  - Empty: no pop occurs.
  - Simultaneous push and pop: the count is unchanged.
- FSM states: IDLE → START → DATA → STOP.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into the 8-bit shifter, drive `tx<=0`, clear the baud counter, go to START.
  - START: after `DIV` clocks, `tx<=shift[0]`, bit counter=0, go to DATA.
  - DATA: every `DIV` clocks, shift right. After bit 7 completes its `DIV` clocks, `tx<=1`, go to STOP.
  - STOP: after `DIV` clocks, if the FIFO is non-empty, pop and re-enter START directly with `tx<=0` (no idle gap). Otherwise go to IDLE.
- `busy = (state != IDLE) || (count != 0)`.
- Reset values: `tx=1`, `busy=0`, `ready=1`, state=IDLE, FIFO empty, all counters 0.
- Reset mid-frame: `tx` goes to 1 immediately (asynchronously), the frame is aborted, and FIFO contents are discarded. The first frame after release starts no earlier than 1 clock after a handshake.

## Timing
- Latency: with the block in IDLE and the FIFO empty, a handshake on edge E0 drives `tx` low after edge E1.
- Frame length: exactly `10*DIV` clocks from `tx` falling to the end of the stop bit.
- Back-to-back frames: consecutive start bits are exactly `10*DIV` clocks apart while the FIFO stays non-empty.
- Pop timing: a FIFO slot frees on the edge that loads the shifter. `ready` rises on the following cycle if the FIFO was full.
- `tx` is glitch-free: driven only from a flop.

## Structure
- Shared package `serial_pkg`:
  - state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3);
  - divisor helper function `baud_div(OSCRATE, BAUDRATE)`.
  - The future receiver-side refactor reuses this package.
- One sub-module, `sync_fifo`:
  - parameter `WIDTH=8`, `DEPTH`;
  - ports `clk`, `rst_n`, `push`, `wdata`, `pop`, `rdata`, `full`, `empty`;
  - `rdata` is the registered head, valid whenever `!empty`.
- FSM, baud counter, bit counter and shifter live in `uart_tx`.

## Test plan
Test parameters: `OSCRATE=16`, `BAUDRATE=1` (so `DIV=16`), `DEPTH=4`, unless stated otherwise.
- Single byte 0xA5 after reset:
  - `tx` falls 1 clock after the handshake;
  - sampling mid-bit gives 0, 1,0,1,0,0,1,0,1, 1;
  - frame is 160 clocks; `busy` drops the cycle after the stop bit ends.
- Burst, `valid` held high with 0x01..0x06:
  - `ready` drops after 5 accepts (4 in the FIFO plus 1 popped into the shifter);
  - `ready` re-rises one clock after each pop;
  - start bits are exactly 160 clocks apart with no idle gap;
  - bytes are received in order.
- Full FIFO with `valid` high and `ready` low: the extra byte 0xFF is never transmitted, and the count stays at 4.
- Reset asserted at clock 70 of a frame: `tx`=1 immediately, `busy`=0 and `ready`=1 during reset, no further frames, queued bytes are lost.
- Defaults (`OSCRATE=12_000_000`, `BAUDRATE=9600`), byte 0x55: each bit measures 1250 clocks, and the frame is 12500 clocks.
- Idle line: no `valid` for 1000 clocks after reset leaves `tx`=1 and `busy`=0 throughout.
